// File: rtl/operand_fetch.sv
// Operand-fetch stage: scoreboard-based hazard stall, same-cycle writeback bypass
// with byte-mask merge, and a single valid/ready output register toward execute.
module operand_fetch #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rd_en,
  output logic [REG_ADDR_W-1:0] rf_rd1_addr,
  output logic [REG_ADDR_W-1:0] rf_rd2_addr,
  input  logic [XLEN-1:0]       rf_rd1_data,
  input  logic [XLEN-1:0]       rf_rd2_data,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic [XLEN/8-1:0]     wb_byte_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_rs1_data,
  output logic [XLEN-1:0]       out_rs2_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_rd_en
);
  localparam int NREG = 1 << REG_ADDR_W;
  localparam int MW   = XLEN / 8;

  function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0] old_v,
                                                 input logic [XLEN-1:0] new_v,
                                                 input logic [MW-1:0]   mask);
    logic [XLEN-1:0] r;
    r = old_v;
    for (int b = 0; b < MW; b++) begin
      if (mask[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  // The RF write lands on the same edge as our capture, so a hitting read is stale.
  function automatic logic [XLEN-1:0] select_operand(input logic [REG_ADDR_W-1:0] rs,
                                                     input logic [XLEN-1:0]       rf_v,
                                                     input logic                  hit,
                                                     input logic [XLEN-1:0]       wdata,
                                                     input logic [MW-1:0]         wmask);
    if (rs == '0) return '0;
    if (hit) return byte_merge(rf_v, wdata, wmask);
    return rf_v;
  endfunction

  logic [NREG-1:0]       busy_q, busy_d;
  logic                  out_valid_q, out_valid_d;
  logic [XLEN-1:0]       out_rs1_q, out_rs1_d;
  logic [XLEN-1:0]       out_rs2_q, out_rs2_d;
  logic [REG_ADDR_W-1:0] out_rd_q, out_rd_d;
  logic                  out_rd_en_q, out_rd_en_d;

  logic wb_hit1, wb_hit2, src_ok1, src_ok2, waw_ok, accept;
  logic [XLEN-1:0] op1, op2;

  assign rf_rd1_addr = in_rs1;
  assign rf_rd2_addr = in_rs2;

  assign wb_hit1 = wb_valid && (wb_addr == in_rs1) && (in_rs1 != '0);
  assign wb_hit2 = wb_valid && (wb_addr == in_rs2) && (in_rs2 != '0);
  assign src_ok1 = !busy_q[in_rs1] || wb_hit1;
  assign src_ok2 = !busy_q[in_rs2] || wb_hit2;
  assign waw_ok  = !in_rd_en || (in_rd == '0) || !busy_q[in_rd] ||
                   (wb_valid && (wb_addr == in_rd));

  assign in_ready = (!out_valid_q || out_ready) && src_ok1 && src_ok2 && waw_ok;
  assign accept   = in_valid && in_ready;

  assign op1 = select_operand(in_rs1, rf_rd1_data, wb_hit1, wb_data, wb_byte_mask);
  assign op2 = select_operand(in_rs2, rf_rd2_data, wb_hit2, wb_data, wb_byte_mask);

  // Clear before set so a retiring and re-issuing writer of one register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    if (accept && in_rd_en && (in_rd != '0)) busy_d[in_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    out_rd_d    = out_rd_q;
    out_rd_en_d = out_rd_en_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_rs1_d   = op1;
      out_rs2_d   = op2;
      out_rd_d    = in_rd;
      out_rd_en_d = in_rd_en;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_rd_q    <= '0;
      out_rd_en_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_rd_q    <= out_rd_d;
      out_rd_en_q <= out_rd_en_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_rs1_data = out_rs1_q;
  assign out_rs2_data = out_rs2_q;
  assign out_rd       = out_rd_q;
  assign out_rd_en    = out_rd_en_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: acts as the RegisterFile, checks every cycle against a
// model that tracks in-flight destinations and post-writeback register contents.
module tb_operand_fetch;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int MW   = XLEN / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, in_rd_en;
  logic [AW-1:0]   in_rs1, in_rs2, in_rd;
  logic [AW-1:0]   rf_rd1_addr, rf_rd2_addr;
  logic [XLEN-1:0] rf_rd1_data, rf_rd2_data;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [MW-1:0]   wb_byte_mask;
  logic            out_valid, out_ready, out_rd_en;
  logic [XLEN-1:0] out_rs1_data, out_rs2_data;
  logic [AW-1:0]   out_rd;

  always #5 clk = ~clk;

  logic [XLEN-1:0] rf [32];
  assign rf_rd1_data = rf[rf_rd1_addr];
  assign rf_rd2_data = rf[rf_rd2_addr];

  operand_fetch #(.XLEN(XLEN), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_en(in_rd_en),
    .rf_rd1_addr(rf_rd1_addr), .rf_rd2_addr(rf_rd2_addr),
    .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_byte_mask(wb_byte_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_en(out_rd_en)
  );

  int nvec = 0;
  int nerr = 0;

  logic [31:0]     mbusy;
  logic            mvalid, mrden;
  logic [XLEN-1:0] m1, m2;
  logic [AW-1:0]   mrd;
  logic [XLEN-1:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mbusy = '0; mvalid = 1'b0; m1 = '0; m2 = '0; mrd = '0; mrden = 1'b0;
  endtask

  // Contents register a will hold once this cycle's writeback has landed.
  function automatic logic [XLEN-1:0] reg_after_wb(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = rf[a];
    if (wb_valid && wb_addr == a)
      for (int b = 0; b < MW; b++) if (wb_byte_mask[b]) v[8*b +: 8] = wb_data[8*b +: 8];
    return v;
  endfunction

  task automatic step();
    logic exp_ready, acc, wv, ok1, ok2, okw;
    logic [XLEN-1:0] e1, e2, w;
    logic [AW-1:0] wa;
    #1;
    ok1 = !mbusy[in_rs1] || (wb_valid && wb_addr == in_rs1);
    ok2 = !mbusy[in_rs2] || (wb_valid && wb_addr == in_rs2);
    okw = !in_rd_en || !mbusy[in_rd] || (wb_valid && wb_addr == in_rd);
    exp_ready = (!mvalid || out_ready) && ok1 && ok2 && okw;
    chk("in_ready", in_ready, exp_ready);
    chk("rf_rd1_addr", rf_rd1_addr, in_rs1);
    chk("rf_rd2_addr", rf_rd2_addr, in_rs2);
    acc = in_valid && exp_ready;
    e1 = reg_after_wb(in_rs1);
    e2 = reg_after_wb(in_rs2);
    w  = reg_after_wb(wb_addr);
    wa = wb_addr;
    wv = wb_valid;
    @(posedge clk);
    #1;
    if (wv && wa != 0) rf[wa] = w;
    if (wv) mbusy[wa] = 1'b0;
    if (acc && in_rd_en && in_rd != 0) mbusy[in_rd] = 1'b1;
    if (acc) begin
      mvalid = 1'b1; m1 = e1; m2 = e2; mrd = in_rd; mrden = in_rd_en;
    end else if (out_ready) begin
      mvalid = 1'b0;
    end
    chk("out_valid", out_valid, mvalid);
    chk("out_rs1_data", out_rs1_data, m1);
    chk("out_rs2_data", out_rs2_data, m2);
    chk("out_rd", out_rd, mrd);
    chk("out_rd_en", out_rd_en, mrden);
    @(negedge clk);
  endtask

  task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic rden);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_en = rden;
  endtask

  task automatic wb(input logic v, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                    input logic [MW-1:0] m);
    wb_valid = v; wb_addr = a; wb_data = d; wb_byte_mask = m;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_en = 0;
    out_ready = 1'b1;
    wb(1'b0, '0, '0, '0);
    for (int i = 0; i < 32; i++) rf[i] = '0;
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_rs1_data", out_rs1_data, 0);
    chk("reset out_rd_en", out_rd_en, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready after reset", in_ready, 1);
    step();

    // Reset in the middle of a stall on x7
    issue(0, 0, 7, 1);
    step();
    issue(7, 0, 0, 0);
    step();
    #1;
    chk("t1 stall", in_ready, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("t1 async out_valid", out_valid, 0);
    chk("t1 async out_rs1", out_rs1_data, 0);
    chk("t1 async out_rd", out_rd, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t1 busy cleared", in_ready, 1);
    step();

    // Plain read, x0 reads as zero
    rf[5] = 32'h0000_0055;
    issue(5, 0, 0, 0);
    step();
    chk("t2 out_valid", out_valid, 1);
    chk("t2 rs1", out_rs1_data, 32'h55);
    chk("t2 rs2", out_rs2_data, 0);

    // RAW stall resolved by full-mask writeback bypass
    issue(0, 0, 7, 1);
    step();
    issue(7, 0, 0, 0);
    #1;
    chk("t3 stall", in_ready, 0);
    step();
    step();
    wb(1'b1, 7, 32'h0000_1234, 4'b1111);
    #1;
    chk("t3 ready on wb", in_ready, 1);
    step();
    chk("t3 bypass", out_rs1_data, 32'h1234);
    wb(1'b0, '0, '0, '0);

    // Partial-mask bypass
    issue(0, 0, 7, 1);
    step();
    rf[7] = 32'hAABB_CCDD;
    issue(7, 0, 0, 0);
    wb(1'b1, 7, 32'hFFFF_FFFF, 4'b0010);
    step();
    chk("t4 merge", out_rs1_data, 32'hAABB_FFDD);
    wb(1'b0, '0, '0, '0);

    // Output backpressure
    issue(5, 0, 0, 0);
    step();
    out_ready = 1'b0;
    issue(7, 0, 3, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5 blocked", in_ready, 0);
      chk("t5 held", out_rs1_data, 32'h55);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("t5 released", in_ready, 1);
    step();
    chk("t5 new rs1", out_rs1_data, 32'hAABB_FFDD);
    chk("t5 new rd", out_rd, 3);
    wb(1'b1, 3, 32'h0, 4'b0000);
    in_valid = 1'b0;
    step();
    wb(1'b0, '0, '0, '0);

    // Same-cycle clear and set on x9
    issue(0, 0, 9, 1);
    step();
    wb(1'b1, 9, 32'hCAFE_0009, 4'b1111);
    #1;
    chk("t6 waw ok", in_ready, 1);
    step();
    wb(1'b0, '0, '0, '0);
    issue(9, 0, 0, 0);
    #1;
    chk("t6 still busy", in_ready, 0);
    step();
    wb(1'b1, 9, 32'h0000_0999, 4'b1111);
    #1;
    chk("t6 wb releases", in_ready, 1);
    step();
    chk("t6 bypass", out_rs1_data, 32'h0000_0999);
    wb(1'b0, '0, '0, '0);

    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_rs1    = AW'($urandom_range(0, 7));
      in_rs2    = AW'($urandom_range(0, 7));
      in_rd     = AW'($urandom_range(0, 7));
      in_rd_en  = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 3) != 0);
      wb($urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), $urandom, MW'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
